divider_seq: RTL and testbench
==============================

DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 Parameter M, default 26: dividend and quotient width in bits, unsigned; matches the multiplier's unsigned operand width.
REQ-002 Parameter D, default 26: divisor and remainder width in bits, unsigned.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a division; accepted only while ready=1.
REQ-006 dividend  input  M  unsigned dividend, sampled on the accepting edge.
REQ-007 divisor  input  D  unsigned divisor, sampled on the accepting edge.
REQ-008 ready  output  1  block can accept start this cycle.
REQ-009 valid  output  1  one-cycle pulse marking quotient/remainder/div_zero as new results.
REQ-010 quotient  output  M  unsigned quotient, floor(dividend/divisor).
REQ-011 remainder  output  D  unsigned remainder, dividend mod divisor.
REQ-012 div_zero  output  1  last result came from a zero divisor.

Function
REQ-013 The FSM SHALL have exactly three states:
- IDLE: ready=1, valid=0.
- BUSY: ready=0, valid=0.
- DONE: ready=1, valid=1.
REQ-014 Acceptance: start=1 with ready=1 on edge k is an accepting edge.
- Latch dividend and divisor.
- Clear the partial remainder and iteration counter.
- Enter BUSY.
REQ-015 BUSY: one restoring radix-2 iteration per edge, MSB of dividend first, M iterations total.
- Shift the partial remainder left, bringing in the next dividend bit.
- If the shifted value is >= divisor, subtract the divisor and set the quotient bit to 1; otherwise set it to 0.
- Hold the partial remainder in D+1 bits so the compare never overflows.
REQ-016 The iteration counter SHALL be ceil(log2(M)) bits wide. The edge completing iteration M (edge k+M) SHALL move BUSY to DONE.
REQ-017 Latency: valid=1 exactly in the cycle after edge k+M, i.e. M cycles after acceptance, for every operand value.
REQ-018 quotient, remainder and div_zero SHALL update only on the edge entering DONE. They hold their values until the next entry to DONE or reset.
REQ-019 DONE lasts one cycle. On edge k+M+1:
- start=1: accept new operands and enter BUSY (back-to-back throughput of M+1 cycles).
- otherwise: enter IDLE.
REQ-020 start=1 while in BUSY SHALL be ignored. Operand input changes during BUSY SHALL NOT affect the result.
REQ-021 Divisor = 0: run the full M iterations (latency unchanged), then report:
- quotient = all ones;
- remainder = dividend[D-1:0], zero-extended when D > M;
- div_zero = 1.
REQ-022 Nonzero divisor: div_zero=0 and results SHALL be bit-exact floor division and modulus.
REQ-023 No combinational path SHALL exist from start, dividend or divisor to any output.

Reset
REQ-024 rst=1 on an edge SHALL force, regardless of state:
- state = IDLE;
- ready = 1; valid = 0;
- quotient = 0; remainder = 0; div_zero = 0;
- internal counter and partial remainder = 0.
REQ-025 Reset during BUSY SHALL abort the operation with no valid pulse. start asserted in the same cycle as rst SHALL be ignored.
REQ-026 In the first cycle after rst deasserts, start=1 SHALL be accepted normally.

Verification
REQ-027 Basic: dividend=100, divisor=7, start one cycle -> valid high exactly 26 cycles after acceptance; quotient=14, remainder=2, div_zero=0.
REQ-028 Extremes: dividend=0x3FFFFFF, divisor=1 -> quotient=0x3FFFFFF, remainder=0. Then dividend=5, divisor=0x3FFFFFF -> quotient=0, remainder=5.
REQ-029 Divide by zero: dividend=0x123, divisor=0 -> after 26 cycles quotient=0x3FFFFFF, remainder=0x123, div_zero=1. The next nonzero-divisor result clears div_zero.
REQ-030 Busy protection: accept 1000/10, pulse start with 9/3 mid-BUSY and alter inputs -> single valid with quotient=100, remainder=0; ready low throughout BUSY.
REQ-031 Back-to-back: start held high continuously with 50/5 then 77/8 -> valid pulses 27 cycles apart carrying (10,0) then (9,5).
REQ-032 Reset mid-op: accept 1000/3, assert rst at cycle 10 -> no valid pulse and all outputs zero. A new start after release returns the correct result with full latency.

Source files
------------

// File: rtl/divider_seq.sv
// Sequential restoring radix-2 unsigned divider: one quotient bit per clock, MSB first.
// A result is presented for one cycle (valid) exactly M cycles after a start is accepted.
`timescale 1ns/1ps
module divider_seq #(
    parameter int M = 26,
    parameter int D = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] dividend,
    input  logic [D-1:0] divisor,
    output logic         ready,
    output logic         valid,
    output logic [M-1:0] quotient,
    output logic [D-1:0] remainder,
    output logic         div_zero
);
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam int RW = D + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_prem;
    logic [M-1:0]  r_qsh;
    logic [D-1:0]  r_dvs;
    logic [M-1:0]  r_quo;
    logic [D-1:0]  r_rem;
    logic          r_dz;

    logic          w_accept;
    logic          w_last;
    logic          w_ge;
    logic [RW:0]   w_shift;
    logic [RW-1:0] w_prem_nxt;
    logic [M-1:0]  w_qsh_nxt;

    assign w_accept = start && ready;
    assign w_last   = (r_cnt == CW'(M - 1));

    // r_qsh starts as the dividend and drains MSB-first while quotient bits fill in from the LSB.
    assign w_shift    = {r_prem, r_qsh[M-1]};
    assign w_ge       = (w_shift >= {2'b00, r_dvs});
    assign w_prem_nxt = w_ge ? RW'(w_shift - {2'b00, r_dvs}) : w_shift[RW-1:0];
    assign w_qsh_nxt  = (r_qsh << 1) | M'(w_ge);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_BUSY;
            S_BUSY:  if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_BUSY : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b1;
        valid = 1'b0;
        case (r_state)
            S_BUSY:  ready = 1'b0;
            S_DONE:  valid = 1'b1;
            default: ;
        endcase
    end

    // A zero divisor needs no special path: every compare succeeds, so the quotient
    // fills with ones and the partial remainder ends up holding the low dividend bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_prem <= '0;
            r_qsh  <= '0;
            r_dvs  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_dz   <= 1'b0;
        end else if (w_accept) begin
            r_qsh  <= dividend;
            r_dvs  <= divisor;
            r_prem <= '0;
            r_cnt  <= '0;
        end else if (r_state == S_BUSY) begin
            r_qsh  <= w_qsh_nxt;
            r_prem <= w_prem_nxt;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
                r_quo <= w_qsh_nxt;
                r_rem <= w_prem_nxt[D-1:0];
                r_dz  <= (r_dvs == '0);
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign div_zero  = r_dz;

endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq: an arithmetic reference model checked every cycle,
// plus hand-computed expectations for each directed operation.
`timescale 1ns/1ps
module tb_divider_seq;
    localparam int M = 26;
    localparam int D = 26;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [M-1:0] dividend = '0;
    logic [D-1:0] divisor = '0;
    logic         ready;
    logic         valid;
    logic [M-1:0] quotient;
    logic [D-1:0] remainder;
    logic         div_zero;

    divider_seq #(.M(M), .D(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .ready    (ready),
        .valid    (valid),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: floor division, and a job takes M cycles from acceptance to result.
    function automatic logic [M-1:0] ref_q(input logic [M-1:0] a, input logic [D-1:0] b);
        if (b == '0) return '1;
        return a / M'(b);
    endfunction

    function automatic logic [D-1:0] ref_r(input logic [M-1:0] a, input logic [D-1:0] b);
        if (b == '0) return D'(a);
        return D'(a % M'(b));
    endfunction

    int           m_left = 0;
    bit           m_live = 1'b0;
    logic         m_valid = 1'b0;
    logic [M-1:0] m_q = '0;
    logic [D-1:0] m_r = '0;
    logic         m_dz = 1'b0;
    logic [M-1:0] p_a = '0;
    logic [D-1:0] p_b = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_live  <= 1'b1;
            m_left  <= 0;
            m_valid <= 1'b0;
            m_q     <= '0;
            m_r     <= '0;
            m_dz    <= 1'b0;
        end else if (m_left != 0) begin
            m_left  <= m_left - 1;
            m_valid <= (m_left == 1);
            if (m_left == 1) begin
                m_q  <= ref_q(p_a, p_b);
                m_r  <= ref_r(p_a, p_b);
                m_dz <= (p_b == '0);
            end
        end else begin
            m_valid <= 1'b0;
            if (start) begin
                p_a    <= dividend;
                p_b    <= divisor;
                m_left <= M;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_ready", 64'(ready), 64'(m_left == 0));
            chk("model_valid", 64'(valid), 64'(m_valid));
            chk("model_quotient", 64'(quotient), 64'(m_q));
            chk("model_remainder", 64'(remainder), 64'(m_r));
            chk("model_div_zero", 64'(div_zero), 64'(m_dz));
        end
    end

    // Caller is just after a rising edge; returns just after the accepting edge.
    task automatic launch(input logic [M-1:0] a, input logic [D-1:0] b, output int acc);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        acc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_res(input string nm, input int acc, input logic [M-1:0] eq,
                            input logic [D-1:0] er, input logic edz);
        bit got;
        got = 1'b0;
        for (int i = 0; i < M + 8; i++) begin
            @(negedge clk);
            if (valid) begin
                got = 1'b1;
                break;
            end
        end
        chk({nm, "_valid_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({nm, "_latency"}, 64'(cyc - acc), 64'(M));
            chk({nm, "_quotient"}, 64'(quotient), 64'(eq));
            chk({nm, "_remainder"}, 64'(remainder), 64'(er));
            chk({nm, "_div_zero"}, 64'(div_zero), 64'(edz));
        end
    endtask

    task automatic do_op(input string nm, input logic [M-1:0] a, input logic [D-1:0] b,
                         input logic [M-1:0] eq, input logic [D-1:0] er, input logic edz);
        int acc;
        @(posedge clk);
        #1;
        launch(a, b, acc);
        wait_res(nm, acc, eq, er, edz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int acc;
        int pulses;
        int rdy_hi;
        int vcyc;
        int np;
        int t[2];
        logic [M-1:0] qv[2];
        logic [D-1:0] rv[2];

        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_valid", 64'(valid), 64'd0);
        chk("reset_quotient", 64'(quotient), 64'd0);
        chk("reset_remainder", 64'(remainder), 64'd0);
        chk("reset_div_zero", 64'(div_zero), 64'd0);
        start = 1'b0;
        rst = 1'b0;

        do_op("basic_100_7", 26'd100, 26'd7, 26'd14, 26'd2, 1'b0);
        do_op("max_by_1", 26'h3FFFFFF, 26'd1, 26'h3FFFFFF, 26'd0, 1'b0);
        do_op("5_by_max", 26'd5, 26'h3FFFFFF, 26'd0, 26'd5, 1'b0);
        do_op("max_by_max", 26'h3FFFFFF, 26'h3FFFFFF, 26'd1, 26'd0, 1'b0);
        do_op("divzero_123", 26'h123, 26'd0, 26'h3FFFFFF, 26'h123, 1'b1);
        do_op("after_divzero", 26'd20, 26'd6, 26'd3, 26'd2, 1'b0);
        do_op("zero_by_zero", 26'd0, 26'd0, 26'h3FFFFFF, 26'd0, 1'b1);
        do_op("pow2_msb", 26'h2000000, 26'h1000, 26'h2000, 26'd0, 1'b0);

        // Start pulse and operand churn while busy must not disturb the running job.
        @(posedge clk);
        #1;
        launch(26'd1000, 26'd10, acc);
        pulses = 0;
        rdy_hi = 0;
        vcyc = 0;
        qv[0] = '0;
        rv[0] = '0;
        for (int i = 1; i <= M + 4; i++) begin
            if (i == 4) begin
                start = 1'b1;
                dividend = 26'd9;
                divisor = 26'd3;
            end
            if (i == 5) begin
                start = 1'b0;
                dividend = M'($urandom);
                divisor = D'($urandom);
            end
            @(negedge clk);
            if (valid) begin
                pulses++;
                vcyc = cyc;
                qv[0] = quotient;
                rv[0] = remainder;
            end
            if ((cyc - acc) < M && ready) rdy_hi++;
            @(posedge clk);
            #1;
        end
        chk("busy_pulses", 64'(pulses), 64'd1);
        chk("busy_latency", 64'(vcyc - acc), 64'(M));
        chk("busy_quotient", 64'(qv[0]), 64'd100);
        chk("busy_remainder", 64'(rv[0]), 64'd0);
        chk("busy_ready_high", 64'(rdy_hi), 64'd0);

        // Start held high across two jobs: second is accepted in the DONE cycle.
        @(posedge clk);
        #1;
        start = 1'b1;
        dividend = 26'd50;
        divisor = 26'd5;
        @(posedge clk);
        #1;
        acc = cyc;
        dividend = 26'd77;
        divisor = 26'd8;
        np = 0;
        t[0] = 0;
        t[1] = 0;
        for (int i = 0; i < 3 * M && np < 2; i++) begin
            @(negedge clk);
            if (valid) begin
                t[np] = cyc;
                qv[np] = quotient;
                rv[np] = remainder;
                np++;
                if (np == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_pulses", 64'(np), 64'd2);
        if (np == 2) begin
            chk("b2b_first_latency", 64'(t[0] - acc), 64'(M));
            chk("b2b_spacing", 64'(t[1] - t[0]), 64'(M + 1));
            chk("b2b_q0", 64'(qv[0]), 64'd10);
            chk("b2b_r0", 64'(rv[0]), 64'd0);
            chk("b2b_q1", 64'(qv[1]), 64'd9);
            chk("b2b_r1", 64'(rv[1]), 64'd5);
        end

        // Reset mid-operation, with start asserted alongside reset.
        @(posedge clk);
        #1;
        launch(26'd1000, 26'd3, acc);
        pulses = 0;
        repeat (9) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        dividend = 26'd9;
        divisor = 26'd3;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dividend = 26'd1000;
        divisor = 26'd3;
        @(negedge clk);
        if (valid) pulses++;
        chk("rstmid_no_valid", 64'(pulses), 64'd0);
        chk("rstmid_ready", 64'(ready), 64'd1);
        chk("rstmid_quotient", 64'(quotient), 64'd0);
        chk("rstmid_remainder", 64'(remainder), 64'd0);
        chk("rstmid_div_zero", 64'(div_zero), 64'd0);
        @(posedge clk);
        #1;
        acc = cyc;
        start = 1'b0;
        wait_res("after_reset", acc, 26'd333, 26'd1, 1'b0);

        do_op("final_123456_789", 26'd123456, 26'd789, 26'd156, 26'd372, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
